// File: rtl/ps_seq_pkg.sv
// Shared constants and types for the program sequencer and its PC stack.
package ps_seq_pkg;

    // Bit positions inside the stcky status vector
    localparam int STK_EMPTY = 0;
    localparam int STK_FULL  = 1;
    localparam int STK_OVF   = 2;
    localparam int STK_UNF   = 3;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_JMP,
        BR_CALL,
        BR_RTS
    } br_kind_e;

endpackage

// File: rtl/ps_pc_stack.sv
// Parametrised LIFO holding return addresses; guards its own push/pop against full/empty.
module ps_pc_stack #(
    parameter int  ADDR_W    = 16,
    parameter int  STK_DEPTH = 4,
    localparam int PTR_W     = $clog2(STK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              ovr_i,
    input  logic [ADDR_W-1:0] push_dt_i,
    input  logic [ADDR_W-1:0] ovr_dt_i,
    output logic [ADDR_W-1:0] top_o,
    output logic [PTR_W-1:0]  ptr_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int IDX_W = $clog2(STK_DEPTH);

    logic [ADDR_W-1:0] mem_q [STK_DEPTH];
    logic [ADDR_W-1:0] mem_d [STK_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  top_idx, push_idx;

    // Pointer counts valid entries, so the top lives one below it
    assign top_idx  = IDX_W'(ptr_q - 1'b1);
    assign push_idx = IDX_W'(ptr_q);
    assign full_o   = (ptr_q == PTR_W'(STK_DEPTH));
    assign empty_o  = (ptr_q == '0);
    assign ptr_o    = ptr_q;
    assign top_o    = empty_o ? '0 : mem_q[top_idx];

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (push_i && !full_o) begin
            mem_d[push_idx] = push_dt_i;
            ptr_d           = ptr_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - 1'b1;
        end else if (ovr_i && !empty_o) begin
            mem_d[top_idx] = ovr_dt_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            for (int i = 0; i < STK_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/ps_seq_stck.sv
// Program sequencer: fetch/decode/execute PC pipeline, branch arbitration with
// a two-slot squash window, idle control and sticky stack status.
module ps_seq_stck
    import ps_seq_pkg::*;
#(
    parameter int  ADDR_W    = 16,
    parameter int  STK_DEPTH = 4,
    localparam int PTR_W     = $clog2(STK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interrupt,
    input  logic              idle_req,
    input  logic              jmp,
    input  logic              call,
    input  logic              rts,
    input  logic [ADDR_W-1:0] tgt,
    input  logic              psh,
    input  logic              pop,
    input  logic              stk_wr_en,
    input  logic [ADDR_W-1:0] stk_wr_dt,
    input  logic              stcky_clr,
    output logic [ADDR_W-1:0] pm_add,
    output logic              pm_cslt,
    output logic [ADDR_W-1:0] faddr,
    output logic [ADDR_W-1:0] daddr,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic [ADDR_W-1:0] stk_top,
    output logic [PTR_W-1:0]  stk_pntr,
    output logic [3:0]        stcky
);

    logic [ADDR_W-1:0] faddr_q, faddr_d, daddr_q, daddr_d, pc_q, pc_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic              idle_q, idle_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    br_kind_e          br_kind;
    logic              stk_push, stk_pop, stk_ovr;
    logic              stk_full, stk_empty;
    logic              ovf_set, unf_set;
    logic [ADDR_W-1:0] push_dt;

    ps_pc_stack #(
        .ADDR_W   (ADDR_W),
        .STK_DEPTH(STK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push_i   (stk_push),
        .pop_i    (stk_pop),
        .ovr_i    (stk_ovr),
        .push_dt_i(push_dt),
        .ovr_dt_i (stk_wr_dt),
        .top_o    (stk_top),
        .ptr_o    (stk_pntr),
        .full_o   (stk_full),
        .empty_o  (stk_empty)
    );

    always_comb begin
        br_kind = BR_NONE;
        if (!idle_q && fcnt_q == 2'd0) begin
            if (rts)       br_kind = BR_RTS;
            else if (call) br_kind = BR_CALL;
            else if (jmp)  br_kind = BR_JMP;
        end
    end

    always_comb begin
        faddr_d  = faddr_q;
        daddr_d  = daddr_q;
        pc_d     = pc_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        push_dt  = pc_q + 1'b1;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (!idle_q) begin
            faddr_d = faddr_q + 1'b1;
            daddr_d = faddr_q;
            pc_d    = daddr_q;
            unique case (br_kind)
                BR_JMP:  faddr_d = tgt;
                BR_CALL: begin
                    faddr_d = tgt;
                    if (stk_full) ovf_set  = 1'b1;
                    else          stk_push = 1'b1;
                end
                BR_RTS: begin
                    if (stk_empty) begin
                        faddr_d = pc_q + 1'b1;
                        unf_set = 1'b1;
                    end else begin
                        faddr_d = stk_top;
                        stk_pop = 1'b1;
                    end
                end
                default: begin
                    // Explicit stack ops only get the stack when no branch claimed it
                    if (psh && !pop) begin
                        push_dt = stk_wr_dt;
                        if (stk_full) ovf_set  = 1'b1;
                        else          stk_push = 1'b1;
                    end else if (pop && !psh) begin
                        if (stk_empty) unf_set = 1'b1;
                        else           stk_pop = 1'b1;
                    end
                end
            endcase
        end
    end

    assign stk_ovr = stk_wr_en && !stk_empty && !stk_push && !stk_pop &&
                     br_kind != BR_CALL && br_kind != BR_RTS;

    always_comb begin
        fcnt_d = fcnt_q;
        if (br_kind != BR_NONE)  fcnt_d = 2'd2;
        else if (fcnt_q != 2'd0) fcnt_d = fcnt_q - 1'b1;

        idle_d = idle_q;
        if (!idle_q && idle_req)     idle_d = 1'b1;
        else if (idle_q && interrupt) idle_d = 1'b0;

        // A new event outranks a clear arriving in the same cycle
        ovf_d = ovf_set ? 1'b1 : (stcky_clr ? 1'b0 : ovf_q);
        unf_d = unf_set ? 1'b1 : (stcky_clr ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            faddr_q <= '0;
            daddr_q <= '0;
            pc_q    <= '0;
            fcnt_q  <= 2'd0;
            idle_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            faddr_q <= faddr_d;
            daddr_q <= daddr_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        stcky            = '0;
        stcky[STK_EMPTY] = stk_empty;
        stcky[STK_FULL]  = stk_full;
        stcky[STK_OVF]   = ovf_q;
        stcky[STK_UNF]   = unf_q;
    end

    assign faddr   = faddr_q;
    assign daddr   = daddr_q;
    assign pc      = pc_q;
    assign pm_add  = faddr_q;
    assign pm_cslt = !idle_q;
    assign flush   = (fcnt_q != 2'd0);

endmodule

// File: tb/tb_ps_seq_stck.sv
// Bench for ps_seq_stck: directed scenarios plus random traffic against a queue-based reference.
module tb_ps_seq_stck;

    localparam int ADDR_W    = 16;
    localparam int STK_DEPTH = 4;
    localparam int PTR_W     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              interrupt, idle_req, jmp, call, rts, psh, pop, stk_wr_en, stcky_clr;
    logic [ADDR_W-1:0] tgt, stk_wr_dt;
    logic [ADDR_W-1:0] pm_add, faddr, daddr, pc, stk_top;
    logic              pm_cslt, flush;
    logic [PTR_W-1:0]  stk_pntr;
    logic [3:0]        stcky;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_faddr, m_daddr, m_pc;
    logic [15:0] m_stk[$];
    int          m_flush;
    bit          m_idle, m_ovf, m_unf;

    ps_seq_stck #(.ADDR_W(ADDR_W), .STK_DEPTH(STK_DEPTH)) dut (
        .clk(clk), .rst(rst), .interrupt(interrupt), .idle_req(idle_req),
        .jmp(jmp), .call(call), .rts(rts), .tgt(tgt), .psh(psh), .pop(pop),
        .stk_wr_en(stk_wr_en), .stk_wr_dt(stk_wr_dt), .stcky_clr(stcky_clr),
        .pm_add(pm_add), .pm_cslt(pm_cslt), .faddr(faddr), .daddr(daddr), .pc(pc),
        .flush(flush), .stk_top(stk_top), .stk_pntr(stk_pntr), .stcky(stcky)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_faddr = '0; m_daddr = '0; m_pc = '0;
        m_stk.delete();
        m_flush = 0; m_idle = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic void model_step();
        logic [15:0] nf = m_faddr;
        logic [15:0] nd = m_daddr;
        logic [15:0] np = m_pc;
        bit taken = 0, touched = 0, set_ovf = 0, set_unf = 0;
        if (!m_idle) begin
            nf = m_faddr + 16'd1; nd = m_faddr; np = m_daddr;
            if (m_flush == 0 && (rts || call || jmp)) begin
                taken = 1;
                if (rts) begin
                    touched = 1;
                    if (m_stk.size() == 0) begin nf = m_pc + 16'd1; set_unf = 1; end
                    else nf = m_stk.pop_back();
                end else if (call) begin
                    touched = 1;
                    nf = tgt;
                    if (m_stk.size() == STK_DEPTH) set_ovf = 1;
                    else m_stk.push_back(m_pc + 16'd1);
                end else begin
                    nf = tgt;
                end
            end else if (psh && !pop) begin
                if (m_stk.size() == STK_DEPTH) set_ovf = 1;
                else begin m_stk.push_back(stk_wr_dt); touched = 1; end
            end else if (pop && !psh) begin
                if (m_stk.size() == 0) set_unf = 1;
                else begin void'(m_stk.pop_back()); touched = 1; end
            end
        end
        if (stk_wr_en && !touched && m_stk.size() > 0) m_stk[m_stk.size()-1] = stk_wr_dt;
        if (taken) m_flush = 2;
        else if (m_flush > 0) m_flush--;
        if (!m_idle) m_idle = idle_req;
        else if (interrupt) m_idle = 0;
        if (stcky_clr) begin m_ovf = 0; m_unf = 0; end
        if (set_ovf) m_ovf = 1;
        if (set_unf) m_unf = 1;
        m_faddr = nf; m_daddr = nd; m_pc = np;
    endfunction

    task automatic check_model(input string ctx);
        logic [3:0]  e_st;
        logic [15:0] e_top;
        e_st  = {m_unf, m_ovf, m_stk.size() == STK_DEPTH, m_stk.size() == 0};
        e_top = (m_stk.size() == 0) ? 16'h0 : m_stk[m_stk.size()-1];
        chk({ctx, ".faddr"}, faddr, m_faddr);
        chk({ctx, ".daddr"}, daddr, m_daddr);
        chk({ctx, ".pc"}, pc, m_pc);
        chk({ctx, ".pm_add"}, pm_add, m_faddr);
        chk({ctx, ".pm_cslt"}, pm_cslt, !m_idle);
        chk({ctx, ".flush"}, flush, m_flush != 0);
        chk({ctx, ".stk_top"}, stk_top, e_top);
        chk({ctx, ".stk_pntr"}, stk_pntr, m_stk.size());
        chk({ctx, ".stcky"}, stcky, e_st);
    endtask

    task automatic clear_inputs();
        interrupt = 0; idle_req = 0; jmp = 0; call = 0; rts = 0; tgt = '0;
        psh = 0; pop = 0; stk_wr_en = 0; stk_wr_dt = '0; stcky_clr = 0;
    endtask

    task automatic tick(input string ctx);
        model_step();
        @(posedge clk);
        #1;
        check_model(ctx);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        check_model("reset");
        chk("reset.stcky_const", stcky, 4'b0001);
        rst = 1'b1;

        repeat (5) tick("run");
        chk("run5.faddr", faddr, 16'd5);
        chk("run5.daddr", daddr, 16'd4);
        chk("run5.pc", pc, 16'd3);
        chk("run5.flush", flush, 1'b0);

        repeat (13) tick("run");
        chk("pre_call.pc", pc, 16'h0010);
        call = 1; tgt = 16'h0040;
        tick("call"); clear_inputs();
        chk("call.faddr", faddr, 16'h0040);
        chk("call.top", stk_top, 16'h0011);
        chk("call.pntr", stk_pntr, 3'd1);
        chk("call.flush1", flush, 1'b1);
        tick("flush");
        chk("call.flush2", flush, 1'b1);
        tick("flush");
        chk("call.flush_end", flush, 1'b0);
        rts = 1;
        tick("rts"); clear_inputs();
        chk("rts.faddr", faddr, 16'h0011);
        chk("rts.pntr", stk_pntr, 3'd0);
        chk("rts.stcky", stcky, 4'b0001);
        repeat (2) tick("run");

        for (int i = 1; i <= 5; i++) begin
            psh = 1; stk_wr_dt = 16'(i);
            tick("psh");
        end
        clear_inputs();
        chk("psh5.pntr", stk_pntr, 3'd4);
        chk("psh5.stcky", stcky, 4'b0110);
        chk("psh5.top", stk_top, 16'd4);
        stcky_clr = 1;
        tick("clr"); clear_inputs();
        chk("clr.stcky", stcky, 4'b0010);
        stk_wr_en = 1; stk_wr_dt = 16'hABCD;
        tick("ovr"); clear_inputs();
        chk("ovr.top", stk_top, 16'hABCD);
        for (int i = 0; i < 5; i++) begin
            pop = 1;
            tick("pop");
        end
        clear_inputs();
        chk("pop_empty.stcky", stcky, 4'b1001);
        stcky_clr = 1;
        tick("clr"); clear_inputs();

        jmp = 1; tgt = 16'h001E;
        tick("jmp"); clear_inputs();
        repeat (4) tick("run");
        chk("pre_rts.pc", pc, 16'h0020);
        rts = 1;
        tick("rts_empty"); clear_inputs();
        chk("rts_empty.faddr", faddr, 16'h0021);
        chk("rts_empty.stcky", stcky, 4'b1001);
        jmp = 1; tgt = 16'h0300;
        tick("jmp_squash"); clear_inputs();
        chk("jmp_squash.faddr", faddr, 16'h0022);
        repeat (2) tick("run");

        jmp = 1; tgt = 16'h0008;
        tick("jmp8"); clear_inputs();
        idle_req = 1;
        tick("idle_req"); clear_inputs();
        chk("idle.cslt", pm_cslt, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick("idle");
            chk("idle.faddr_hold", faddr, 16'h0009);
        end
        interrupt = 1;
        tick("wake"); clear_inputs();
        chk("wake.cslt", pm_cslt, 1'b1);
        tick("resume");
        chk("resume.faddr", faddr, 16'h000A);

        stcky_clr = 1; psh = 1; stk_wr_dt = 16'h0055;
        tick("psh"); clear_inputs();
        psh = 1; stk_wr_dt = 16'h0100;
        tick("psh"); clear_inputs();
        rts = 1; call = 1; jmp = 1; psh = 1; tgt = 16'h0500; stk_wr_dt = 16'h0777;
        tick("multi"); clear_inputs();
        chk("multi.faddr", faddr, 16'h0100);
        chk("multi.pntr", stk_pntr, 3'd1);
        chk("multi.top", stk_top, 16'h0055);

        for (int n = 0; n < 400; n++) begin
            jmp       = ($urandom_range(7) == 0);
            call      = ($urandom_range(7) == 0);
            rts       = ($urandom_range(7) == 0);
            psh       = ($urandom_range(3) == 0);
            pop       = ($urandom_range(3) == 0);
            stk_wr_en = ($urandom_range(7) == 0);
            stcky_clr = ($urandom_range(15) == 0);
            idle_req  = ($urandom_range(31) == 0);
            interrupt = ($urandom_range(3) == 0);
            tgt       = 16'($urandom);
            stk_wr_dt = 16'($urandom);
            tick("rand");
        end
        clear_inputs();

        #2 rst = 1'b0;
        #1;
        model_reset();
        check_model("midreset");
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 40; n++) begin
            call = ($urandom_range(3) == 0);
            rts  = ($urandom_range(3) == 0);
            psh  = ($urandom_range(2) == 0);
            pop  = ($urandom_range(3) == 0);
            tgt  = 16'($urandom);
            stk_wr_dt = 16'($urandom);
            tick("post_reset");
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps_seq_stck.md
# ps_seq_stck

Parametrised program sequencer with a configurable-depth PC stack. It replaces the fixed 2-entry stack and plain increment fetch with call/return/jump redirection, explicit push/pop, sticky overflow/underflow flags and a fetch-squash counter. It sits between program memory and the instruction decoders and drives the PM address and the fetch/decode/execute PC pipeline.

## Interface
- ADDR_W, 16, width of PM addresses and stack entries
- STK_DEPTH, 4, PC stack entries (≥2, power of two)
- PTR_W, $clog2(STK_DEPTH)+1, derived localparam, stack pointer width

- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- interrupt  in  1  wakes the sequencer from idle
- idle_req  in  1  enter idle, qualified by executing instruction
- jmp  in  1  taken jump at execute stage
- call  in  1  taken call at execute stage
- rts  in  1  return at execute stage
- tgt  in  ADDR_W  jump/call target
- psh  in  1  explicit push of stk_wr_dt
- pop  in  1  explicit pop
- stk_wr_en  in  1  overwrite top-of-stack
- stk_wr_dt  in  ADDR_W  push/overwrite data
- stcky_clr  in  1  clear overflow/underflow sticky bits
- pm_add  out  ADDR_W  PM fetch address (= faddr)
- pm_cslt  out  1  PM chip select (= !idle)
- faddr, daddr, pc  out  ADDR_W  fetch/decode/execute addresses
- flush  out  1  squash the instruction now at execute
- stk_top  out  ADDR_W  top entry; 0 when empty
- stk_pntr  out  PTR_W  number of valid entries
- stcky  out  4  {underflow, overflow, full, empty}

## Operation
- Reset values: faddr=daddr=pc=0, stk_pntr=0, stcky=4'b0001, idle=0, flush=0, all entries 0, pm_cslt=1.
- Normal: each edge when not idle, faddr<=faddr+1, daddr<=faddr, pc<=daddr; wraps 0xFFFF→0 silently.
- Branch accepted only when !idle and flush counter is 0; priority rts > call > jmp. Excess requests ignored.
  - jmp: faddr<=tgt.
  - call: faddr<=tgt; push pc+1. If full: no push, overflow set, jump still taken.
  - rts: faddr<=stk_top; pop. If empty: faddr<=pc+1 (fall-through), underflow set.
  - Accepted branch loads flush counter with 2.
- Explicit stack ops apply only when no branch is accepted that cycle; psh and pop together → no-op. psh when full → overflow set, no change; pop when empty → underflow set.
- stk_wr_en: overwrites entry stk_pntr-1; ignored when empty or when any push/pop/call/rts is accepted the same cycle.
- stcky[0]=(stk_pntr==0), stcky[1]=(stk_pntr==STK_DEPTH), combinational from pointer. Bits 3:2 stay set until stcky_clr or reset; a set event in the same cycle as stcky_clr wins.
- Idle: idle_req while !idle → idle next edge; faddr/daddr/pc frozen; branch, psh, pop ignored. Interrupt while idle → idle cleared next edge. idle_req and interrupt together while !idle → enter idle.

## Timing
- Stack pointer, entries, sticky bits update at the edge ending the request cycle; stk_top reflects it the next cycle.
- flush high for exactly 2 cycles after the accepting edge (counter 2→1→0); those are the two squashed slots.
- pm_add/pm_cslt combinational from registered state; no input→output combinational path except none (all outputs registered or decoded from registers).
- Reset asserted mid-operation returns all state to reset values asynchronously, stack contents included.

## Structure
- Package ps_seq_pkg: sticky bit index constants (STK_EMPTY=0, STK_FULL=1, STK_OVF=2, STK_UNF=3), branch-kind enum {BR_NONE, BR_JMP, BR_CALL, BR_RTS}.
- Sub-module ps_pc_stack: parametrised LIFO (entries, pointer, push/pop/overwrite, full/empty); top level holds pipeline, arbitration, flush counter, idle, sticky bits.

## Test plan
- Reset, release, run 5 cycles → faddr=5, daddr=4, pc=3, stcky=0001, flush=0.
- call tgt=0x0040 at pc=0x0010 → faddr=0x0040 next cycle, stk_top=0x0011, stk_pntr=1, flush high 2 cycles; then rts → faddr=0x0011, stk_pntr=0, stcky=0001.
- 5 psh with STK_DEPTH=4 (data 1..5) → stk_pntr=4, stcky=0110, stk_top=4; stcky_clr → 0010.
- rts when empty at pc=0x0020 → faddr=0x0021, stcky=1001; jmp asserted during flush window → ignored.
- idle_req at faddr=0x0008 → pm_cslt=0, faddr held 0x0009 for 10 cycles; interrupt → increment resumes next cycle.
- rts+call+jmp same cycle with stack top 0x0100 → faddr=0x0100, stk_pntr decremented by 1, psh same cycle ignored.
